// File: rtl/aes_pkg.sv
// aes_pkg
//   Shared types, constants and GF(2^8) helpers for the AES round datapath.
//   No ports; imported by mix_col_sched and the column mixers.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  col_t;

    typedef enum logic [1:0] {
        IDLE,
        MIX,
        HOLD
    } fsm_t;

    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_INV = 1'b1;

    // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant as a sum of x^0..x^3 terms; this is
    // enough for every MixColumns / InvMixColumns coefficient.
    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (k[0] ? a  : 8'h00) ^
               (k[1] ? x2 : 8'h00) ^
               (k[2] ? x4 : 8'h00) ^
               (k[3] ? x8 : 8'h00);
    endfunction

endpackage

// File: rtl/mix_col_sched_mixers.sv
// mixCol32 / invMixCol32
//   Purely combinational single-column (Inv)MixColumns.
//   Ports:
//     col_i  32-bit column, row 0 in [31:24], row 3 in [7:0]
//     col_o  32-bit mixed column, same byte order
module mixCol32
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col_i;

    // Circulant matrix rows {2,3,1,1}.
    assign col_o[31:24] = gfMul(a0, 4'd2) ^ gfMul(a1, 4'd3) ^ a2 ^ a3;
    assign col_o[23:16] = a0 ^ gfMul(a1, 4'd2) ^ gfMul(a2, 4'd3) ^ a3;
    assign col_o[15:8]  = a0 ^ a1 ^ gfMul(a2, 4'd2) ^ gfMul(a3, 4'd3);
    assign col_o[7:0]   = gfMul(a0, 4'd3) ^ a1 ^ a2 ^ gfMul(a3, 4'd2);

endmodule

module invMixCol32
    import aes_pkg::*;
(
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    logic [7:0] a0, a1, a2, a3;

    assign {a0, a1, a2, a3} = col_i;

    // Circulant matrix rows {14,11,13,9}.
    assign col_o[31:24] = gfMul(a0, 4'd14) ^ gfMul(a1, 4'd11) ^ gfMul(a2, 4'd13) ^ gfMul(a3, 4'd9);
    assign col_o[23:16] = gfMul(a0, 4'd9)  ^ gfMul(a1, 4'd14) ^ gfMul(a2, 4'd11) ^ gfMul(a3, 4'd13);
    assign col_o[15:8]  = gfMul(a0, 4'd13) ^ gfMul(a1, 4'd9)  ^ gfMul(a2, 4'd14) ^ gfMul(a3, 4'd11);
    assign col_o[7:0]   = gfMul(a0, 4'd11) ^ gfMul(a1, 4'd13) ^ gfMul(a2, 4'd9)  ^ gfMul(a3, 4'd14);

endmodule

// File: rtl/mix_col_sched.sv
// mix_col_sched
//   Applies (Inv)MixColumns to a 128-bit AES state one column per cycle,
//   reusing one forward and one inverse column mixer.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     in_valid/in_ready    input handshake; in_state, in_mode, in_skip
//                          are captured on the accept edge
//     out_valid/out_ready  output handshake; out_state is held stable
//                          while out_valid is high
//     busy                 high whenever the FSM is not IDLE
module mix_col_sched
    import aes_pkg::*;
#(
    parameter int NUM_COLS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_mode,
    input  logic         in_skip,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam logic [1:0] LastCol = 2'(NUM_COLS - 1);

    fsm_t   state_q, state_d;
    state_t data_q, data_d;
    state_t outState_q;
    logic   [1:0] colCnt_q;
    logic   mode_q;
    logic   outValid_q;

    col_t   colIn, fwdCol, invCol, colOut;

    mixCol32 uFwd (
        .col_i (colIn),
        .col_o (fwdCol)
    );

    invMixCol32 uInv (
        .col_i (colIn),
        .col_o (invCol)
    );

    assign colOut = (mode_q == MODE_INV) ? invCol : fwdCol;

    // Column 0 lives in the top word, so the slot for colCnt_q is picked
    // MSB-first; the mixed column is written back into the same slot.
    always_comb begin
        colIn  = data_q[127:96];
        data_d = data_q;
        case (colCnt_q)
            2'd0: begin colIn = data_q[127:96]; data_d[127:96] = colOut; end
            2'd1: begin colIn = data_q[95:64];  data_d[95:64]  = colOut; end
            2'd2: begin colIn = data_q[63:32];  data_d[63:32]  = colOut; end
            default: begin colIn = data_q[31:0]; data_d[31:0]  = colOut; end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state. HOLD only releases once out_valid is actually up, which
    // matters for skip blocks whose first HOLD cycle loads the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = in_skip ? HOLD : MIX;
                end
            end
            MIX: begin
                if (colCnt_q == LastCol) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (outValid_q && out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready = (state_q == IDLE);
        busy     = (state_q != IDLE);
    end

    assign out_valid = outValid_q;
    assign out_state = outState_q;

    // Datapath. A mixed block publishes its result on the edge that writes
    // the last column; a skip block publishes the captured state during its
    // first HOLD cycle, giving one cycle of latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= '0;
            outState_q <= '0;
            colCnt_q   <= '0;
            mode_q     <= MODE_FWD;
            outValid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_state;
                        mode_q   <= in_mode;
                        colCnt_q <= '0;
                    end
                end
                MIX: begin
                    data_q   <= data_d;
                    colCnt_q <= colCnt_q + 2'd1;
                    if (colCnt_q == LastCol) begin
                        outState_q <= data_d;
                        outValid_q <= 1'b1;
                    end
                end
                HOLD: begin
                    if (!outValid_q) begin
                        outState_q <= data_q;
                        outValid_q <= 1'b1;
                    end else if (out_ready) begin
                        outValid_q <= 1'b0;
                    end
                end
                default: outValid_q <= 1'b0;
            endcase
        end
    end

endmodule
